// File: rtl/clkdiv_prog_multi.sv
// clkdiv_prog_multi
//   Multi-channel programmable clock divider. Each channel divides the system
//   clock by 2*half_q to make a square-wave enable clock. A new half-period can
//   be loaded at any time. It takes effect only at the end of a full period
//   (the 1->0 edge of clk_out), so the output never produces a short pulse.
//   There is also a global strobe that realigns the phase of every channel.
//
// Parameters
//   CH        number of independent channels (1..8)
//   DIV_W     width of the half-period value and of the counter
//   RST_HALF  half-period loaded into every channel on reset
//
// Ports
//   clk      system clock, all logic on posedge
//   rst      synchronous, active-low reset
//   en       per-channel run enable; 0 freezes the channel
//   load     per-channel strobe: capture the half_in slice as the pending divisor
//   half_in  packed half-periods; channel i uses [i*DIV_W +: DIV_W]
//   sync     strobe: restart the phase of all channels, applying pending divisors
//   clk_out  divided outputs (registered)
//   tick     one-cycle pulse in the cycle clk_out[i] becomes 1
//   pend     a loaded divisor is waiting for the period boundary

module clkdiv_prog_multi #(
  parameter int          CH       = 2,
  parameter int          DIV_W    = 26,
  parameter int unsigned RST_HALF = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic [CH-1:0]         load,
  input  logic [CH*DIV_W-1:0]   half_in,
  input  logic                  sync,
  output logic [CH-1:0]         clk_out,
  output logic [CH-1:0]         tick,
  output logic [CH-1:0]         pend
);

  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_HALF);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] load_val;
    logic [DIV_W-1:0] next_div;
    logic             clk_r;
    logic             tick_r;
    logic             pend_r;
    logic             at_end;

    // A load in the same cycle as the boundary wins over the older shadow value.
    assign load_val = half_in[i*DIV_W +: DIV_W];
    assign next_div = load[i] ? load_val : shadow;
    assign at_end   = (cnt == half_q - ONE);

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt    <= '0;
        half_q <= RST_VAL;
        shadow <= '0;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
        pend_r <= 1'b0;
      end else if (sync) begin
        // Realign: restart from the low phase with the newest divisor available.
        cnt    <= '0;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
        pend_r <= 1'b0;
        if (load[i]) begin
          shadow <= load_val;
          half_q <= load_val;
        end else if (pend_r) begin
          half_q <= shadow;
        end
      end else begin
        tick_r <= 1'b0;
        if (load[i]) begin
          shadow <= load_val;
          pend_r <= 1'b1;
        end
        if (half_q == '0) begin
          // Stopped channel: there is no period to finish, so a load starts it at once.
          cnt   <= '0;
          clk_r <= 1'b0;
          if (load[i]) begin
            half_q <= load_val;
            pend_r <= 1'b0;
          end
        end else if (en[i]) begin
          if (at_end) begin
            cnt   <= '0;
            clk_r <= ~clk_r;
            if (!clk_r) begin
              tick_r <= 1'b1;
            end else if (pend_r || load[i]) begin
              // Falling edge closes a full period: safe point to switch divisor.
              half_q <= next_div;
              pend_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
      end
    end

    assign clk_out[i] = clk_r;
    assign tick[i]    = tick_r;
    assign pend[i]    = pend_r;
  end

endmodule

// File: tb/tb_clkdiv_prog_multi.sv
// tb_clkdiv_prog_multi
//   Directed bench for clkdiv_prog_multi with CH=2, DIV_W=8, RST_HALF=4.
//   k counts clock edges since the last reset release; outputs are sampled
//   1 time unit after each posedge and inputs are changed at the same point.

module tb_clkdiv_prog_multi;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  load;
  logic [15:0] half_in;
  logic        sync;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  pend;

  int tests_run;
  int tests_failed;
  int k;

  clkdiv_prog_multi #(
    .CH       (2),
    .DIV_W    (8),
    .RST_HALF (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .half_in (half_in),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    en      = 2'b00;
    load    = 2'b00;
    half_in = 16'h0000;
    sync    = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    en  = 2'b11;
    k   = 0;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    en      = 2'b11;
    load    = 2'b11;
    half_in = 16'h0101;
    sync    = 1'b0;
    cyc();
    cyc();
    tests_run++;
    if ({clk_out, tick, pend} !== 6'b000000) begin
      $display("[TB] FAIL reset_outputs got %b exp %b", {clk_out, tick, pend}, 6'b000000);
      tests_failed++;
    end
  endtask

  task automatic test_basic();
    logic c, t;
    do_reset();
    for (int j = 1; j <= 20; j++) begin
      cyc();
      c = ((k / 4) % 2) == 1;
      t = (k % 8) == 4;
      tests_run++;
      if ({clk_out, tick, pend} !== {c, c, t, t, 2'b00}) begin
        $display("[TB] FAIL basic k=%0d got %b exp %b", k, {clk_out, tick, pend}, {c, c, t, t, 2'b00});
        tests_failed++;
      end
    end
  endtask

  task automatic test_load_midhigh();
    logic c0, t0, p0, c1, t1;
    do_reset();
    repeat (21) cyc();
    load    = 2'b01;
    half_in = 16'h0002;
    for (int j = 22; j <= 36; j++) begin
      cyc();
      load = 2'b00;
      if (k < 24) begin
        c0 = 1'b1; t0 = 1'b0; p0 = 1'b1;
      end else begin
        c0 = (((k - 24) / 2) % 2) == 1;
        t0 = (k >= 26) && (((k - 26) % 4) == 0);
        p0 = 1'b0;
      end
      c1 = ((k / 4) % 2) == 1;
      t1 = (k % 8) == 4;
      tests_run++;
      if ({clk_out[1], tick[1], pend[1], clk_out[0], tick[0], pend[0]} !== {c1, t1, 1'b0, c0, t0, p0}) begin
        $display("[TB] FAIL load_midhigh k=%0d got %b exp %b", k,
                 {clk_out[1], tick[1], pend[1], clk_out[0], tick[0], pend[0]}, {c1, t1, 1'b0, c0, t0, p0});
        tests_failed++;
      end
    end
  endtask

  task automatic test_stop_restart();
    logic c1, t1, p1;
    do_reset();
    cyc();
    load    = 2'b10;
    half_in = 16'h0000;
    for (int j = 2; j <= 27; j++) begin
      cyc();
      load = 2'b00;
      p1 = (k >= 2) && (k <= 7);
      c1 = ((k >= 4) && (k <= 7)) || ((k >= 24) && (k <= 26));
      t1 = (k == 4) || (k == 24);
      tests_run++;
      if ({clk_out[1], tick[1], pend[1]} !== {c1, t1, p1}) begin
        $display("[TB] FAIL stop_restart k=%0d got %b exp %b", k, {clk_out[1], tick[1], pend[1]}, {c1, t1, p1});
        tests_failed++;
      end
      if (k == 20) begin
        load    = 2'b10;
        half_in = 16'h0300;
      end
    end
  endtask

  task automatic test_freeze();
    logic c0, t0, c1, t1;
    do_reset();
    repeat (5) cyc();
    en = 2'b10;
    for (int j = 6; j <= 21; j++) begin
      cyc();
      c0 = (k < 13) || ((k >= 17) && (k < 21));
      t0 = (k == 17);
      c1 = ((k / 4) % 2) == 1;
      t1 = (k % 8) == 4;
      tests_run++;
      if ({clk_out, tick, pend} !== {c1, c0, t1, t0, 2'b00}) begin
        $display("[TB] FAIL freeze k=%0d got %b exp %b", k, {clk_out, tick, pend}, {c1, c0, t1, t0, 2'b00});
        tests_failed++;
      end
      if (k == 10) en = 2'b11;
    end
  endtask

  task automatic test_sync();
    logic [3:0] e;
    do_reset();
    cyc();
    load    = 2'b11;
    half_in = 16'h0503;
    cyc();
    load = 2'b00;
    tests_run++;
    if ({clk_out, pend} !== 4'b0011) begin
      $display("[TB] FAIL sync_pend_both got %b exp %b", {clk_out, pend}, 4'b0011);
      tests_failed++;
    end
    repeat (9) cyc();
    tests_run++;
    if ({clk_out, pend} !== 4'b0100) begin
      $display("[TB] FAIL sync_new_halves k=%0d got %b exp %b", k, {clk_out, pend}, 4'b0100);
      tests_failed++;
    end
    repeat (3) cyc();
    tests_run++;
    if (clk_out !== 2'b10) begin
      $display("[TB] FAIL sync_pre_state k=%0d got %b exp %b", k, clk_out, 2'b10);
      tests_failed++;
    end
    sync    = 1'b1;
    load    = 2'b10;
    half_in = 16'h0200;
    cyc();
    sync = 1'b0;
    load = 2'b00;
    tests_run++;
    if ({clk_out, tick, pend} !== 6'b000000) begin
      $display("[TB] FAIL sync_clear got %b exp %b", {clk_out, tick, pend}, 6'b000000);
      tests_failed++;
    end
    for (int j = 16; j <= 19; j++) begin
      cyc();
      case (k)
        16:      e = 4'b0000;
        17:      e = 4'b1010;
        18:      e = 4'b1101;
        default: e = 4'b0100;
      endcase
      tests_run++;
      if ({clk_out, tick} !== e) begin
        $display("[TB] FAIL sync_realign k=%0d got %b exp %b", k, {clk_out, tick}, e);
        tests_failed++;
      end
    end
  endtask

  task automatic test_reset_pending();
    logic c, t;
    do_reset();
    repeat (4) cyc();
    load    = 2'b01;
    half_in = 16'h0002;
    cyc();
    load = 2'b00;
    tests_run++;
    if ({clk_out, pend} !== 4'b1101) begin
      $display("[TB] FAIL rstpend_before got %b exp %b", {clk_out, pend}, 4'b1101);
      tests_failed++;
    end
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    tests_run++;
    if ({clk_out, tick, pend} !== 6'b000000) begin
      $display("[TB] FAIL rstpend_reset got %b exp %b", {clk_out, tick, pend}, 6'b000000);
      tests_failed++;
    end
    for (int j = 7; j <= 14; j++) begin
      cyc();
      c = (k >= 10) && (k < 14);
      t = (k == 10);
      tests_run++;
      if ({clk_out, tick, pend} !== {c, c, t, t, 2'b00}) begin
        $display("[TB] FAIL rstpend_after k=%0d got %b exp %b", k, {clk_out, tick, pend}, {c, c, t, t, 2'b00});
        tests_failed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic c, t, p0;
    do_reset();
    cyc();
    load    = 2'b01;
    half_in = 16'h0006;
    cyc();
    half_in = 16'h0002;
    cyc();
    load = 2'b00;
    tests_run++;
    if (pend !== 2'b01) begin
      $display("[TB] FAIL b2b_pend got %b exp %b", pend, 2'b01);
      tests_failed++;
    end
    for (int j = 4; j <= 14; j++) begin
      cyc();
      load = 2'b00;
      c  = ((k >= 4) && (k <= 7)) || ((k >= 10) && (k <= 11)) || (k == 14);
      t  = (k == 4) || (k == 10) || (k == 14);
      p0 = (k < 8);
      tests_run++;
      if ({clk_out, tick, pend} !== {c, c, t, t, 1'b0, p0}) begin
        $display("[TB] FAIL b2b k=%0d got %b exp %b", k, {clk_out, tick, pend}, {c, c, t, t, 1'b0, p0});
        tests_failed++;
      end
      if (k == 7) begin
        load    = 2'b10;
        half_in = 16'h0200;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    k            = 0;
    rst          = 1'b0;
    en           = 2'b00;
    load         = 2'b00;
    half_in      = 16'h0000;
    sync         = 1'b0;
    test_reset();
    test_basic();
    test_load_midhigh();
    test_stop_restart();
    test_freeze();
    test_sync();
    test_reset_pending();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
